// File: rtl/paddle_draw_ctrl.sv
`default_nettype none
// ============================================================================
// paddle_draw_ctrl : erase / load / draw sequencer for the paddle plot datapath
// Rev 1.0
// ============================================================================
module paddle_draw_ctrl #(
   parameter int PADDLE_W = 16,
   parameter int PADDLE_H = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       go,
   output logic       ld_x,
   output logic       ld_y,
   output logic [4:0] counter_x,
   output logic [4:0] counter_y,
   output logic       plot,
   output logic       erase,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ERASE = 3'd1,
      S_LOAD  = 3'd2,
      S_DRAW  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [4:0] X_LAST = 5'(PADDLE_W - 1);
   localparam logic [4:0] Y_LAST = 5'(PADDLE_H - 1);

   state_t     state_q, state_d;
   logic [4:0] cx_q, cx_d;
   logic [4:0] cy_q, cy_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cx_q    <= 5'd0;
         cy_q    <= 5'd0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
      end
   end

   // Counters sit at zero outside the two sweeps so every sweep starts at (0,0).
   always_comb begin
      state_d = state_q;
      cx_d    = 5'd0;
      cy_d    = 5'd0;
      case (state_q)
         S_IDLE: begin
            if (go) state_d = S_ERASE;
         end
         S_ERASE, S_DRAW: begin
            if (cx_q == X_LAST) begin
               if (cy_q == Y_LAST) begin
                  state_d = (state_q == S_ERASE) ? S_LOAD : S_DONE;
               end else begin
                  cy_d = cy_q + 5'd1;
               end
            end else begin
               cx_d = cx_q + 5'd1;
               cy_d = cy_q;
            end
         end
         S_LOAD:  state_d = S_DRAW;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ld_x  = 1'b1;
      ld_y  = 1'b1;
      plot  = 1'b0;
      erase = 1'b0;
      busy  = 1'b1;
      done  = 1'b0;
      case (state_q)
         S_IDLE:  busy = 1'b0;
         S_ERASE: begin
            plot  = 1'b1;
            erase = 1'b1;
         end
         S_LOAD: begin
            ld_x = 1'b0;
            ld_y = 1'b0;
         end
         S_DRAW:  plot = 1'b1;
         S_DONE:  done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   assign counter_x = cx_q;
   assign counter_y = cy_q;

endmodule
`default_nettype wire

// File: tb/tb_paddle_draw_ctrl.sv
`default_nettype none
// ============================================================================
// tb_paddle_draw_ctrl : directed vectors for paddle_draw_ctrl (4x2 and 1x1)
// Rev 1.0
// ============================================================================
module tb_paddle_draw_ctrl;

   logic       clock;
   logic       reset_n;
   logic       go_a, go_b;
   logic       ldx_a, ldy_a, plot_a, erase_a, busy_a, done_a;
   logic       ldx_b, ldy_b, plot_b, erase_b, busy_b, done_b;
   logic [4:0] cx_a, cy_a, cx_b, cy_b;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   localparam logic [15:0] C_RST_VEC = 16'h0C00;

   paddle_draw_ctrl #(.PADDLE_W(4), .PADDLE_H(2)) u_dut_a (
      .clock(clock), .reset_n(reset_n), .go(go_a),
      .ld_x(ldx_a), .ld_y(ldy_a), .counter_x(cx_a), .counter_y(cy_a),
      .plot(plot_a), .erase(erase_a), .busy(busy_a), .done(done_a)
   );

   paddle_draw_ctrl #(.PADDLE_W(1), .PADDLE_H(1)) u_dut_b (
      .clock(clock), .reset_n(reset_n), .go(go_b),
      .ld_x(ldx_b), .ld_y(ldy_b), .counter_x(cx_b), .counter_y(cy_b),
      .plot(plot_b), .erase(erase_b), .busy(busy_b), .done(done_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // {busy, done, plot, erase, ld_x, ld_y, counter_x, counter_y}
   function automatic logic [15:0] obs_vec(input int sel);
      if (sel == 0)
         return {busy_a, done_a, plot_a, erase_a, ldx_a, ldy_a, cx_a, cy_a};
      return {busy_b, done_b, plot_b, erase_b, ldx_b, ldy_b, cx_b, cy_b};
   endfunction

   // Expected outputs in cycle c after go was sampled at edge 0.
   function automatic logic [15:0] exp_vec(input int c, input int w, input int h);
      int         wh   = w * h;
      int         idx  = 0;
      logic [4:0] cx   = 5'd0;
      logic [4:0] cy   = 5'd0;
      logic       bsy  = 1'b0;
      logic       dn   = 1'b0;
      logic       plt  = 1'b0;
      logic       ers  = 1'b0;
      logic       ldx  = 1'b1;
      logic       ldy  = 1'b1;
      if (c >= 1 && c <= wh) begin
         idx = c - 1;
         bsy = 1'b1; plt = 1'b1; ers = 1'b1;
         cx  = 5'(idx % w); cy = 5'(idx / w);
      end else if (c == wh + 1) begin
         bsy = 1'b1; ldx = 1'b0; ldy = 1'b0;
      end else if (c >= wh + 2 && c <= 2 * wh + 1) begin
         idx = c - wh - 2;
         bsy = 1'b1; plt = 1'b1;
         cx  = 5'(idx % w); cy = 5'(idx / w);
      end else if (c == 2 * wh + 2) begin
         bsy = 1'b1; dn = 1'b1;
      end
      return {bsy, dn, plt, ers, ldx, ldy, cx, cy};
   endfunction

   task automatic set_go(input int sel, input logic v);
      if (sel == 0) go_a = v;
      else          go_b = v;
   endtask

   // Issues go at edge 0, then checks ncyc cycles; optional extra go pulse
   // and optional asynchronous reset drop in a given cycle.
   task automatic run_op(input int sel, input int w, input int h, input int ncyc,
                         input bit hold, input int pulse_at, input int rst_at);
      int ce;
      @(negedge clock);
      set_go(sel, 1'b1);
      @(posedge clock);
      #1;
      if (!hold) set_go(sel, 1'b0);
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clock);
         ce = hold ? ((c - 1) % (2 * w * h + 3)) + 1 : c;
         check_val($sformatf("op%0d_c%0d", sel, c), obs_vec(sel), exp_vec(ce, w, h));
         if (c == pulse_at)     set_go(sel, 1'b1);
         if (c == pulse_at + 1) set_go(sel, 1'b0);
         if (c == rst_at) begin
            #1 reset_n = 1'b0;
            #1 check_val($sformatf("async_rst%0d_c%0d", sel, c), obs_vec(sel), C_RST_VEC);
            break;
         end
      end
      set_go(sel, 1'b0);
   endtask

   initial begin
      go_a    = 1'b0;
      go_b    = 1'b0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      check_val("rst_a", obs_vec(0), C_RST_VEC);
      check_val("rst_b", obs_vec(1), C_RST_VEC);
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_val("rst_held_a", obs_vec(0), C_RST_VEC);
      reset_n = 1'b1;
      @(negedge clock);
      check_val("idle_a", obs_vec(0), C_RST_VEC);
      check_val("idle_b", obs_vec(1), C_RST_VEC);

      // 4x2 single operation, plus idle afterwards
      run_op(0, 4, 2, 20, 1'b0, -10, -1);
      // go pulsed during DRAW is ignored
      run_op(0, 4, 2, 24, 1'b0, 12, -1);
      // 1x1 operation
      run_op(1, 1, 1, 7, 1'b0, -10, -1);
      // go held high: one IDLE cycle between DONE and next ERASE
      run_op(0, 4, 2, 23, 1'b1, -10, -1);
      repeat (25) @(negedge clock);
      check_val("idle_after_hold", obs_vec(0), C_RST_VEC);

      // reset dropped mid-DRAW aborts with no done pulse
      run_op(0, 4, 2, 20, 1'b0, -10, 12);
      @(negedge clock);
      check_val("rst_mid_held", obs_vec(0), C_RST_VEC);
      reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         check_val($sformatf("post_abort_c%0d", c), obs_vec(0), C_RST_VEC);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
`default_nettype wire
